// File: rtl/seg_scan_step.sv
// seg_scan_step: debounced single-step button plus 4-digit multiplexed hex display of a selected debug word.
// Ports:
//   CLK        - clock, all logic on rising edge
//   Reset      - synchronous reset, active-low
//   btn_step   - raw bouncing push-button, high = pressed
//   sel        - word select: 0=sign1, 1=sign2, 2=sign3, 3=sign4
//   sign1..4   - 16-bit debug words
//   step_pulse - one-cycle pulse per accepted press
//   an         - digit enables, active-low, bit 0 = rightmost
//   seg        - segments, active-low, {dp,g,f,e,d,c,b,a}
module seg_scan_step #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        btn_step,
    input  logic [1:0]  sel,
    input  logic [15:0] sign1,
    input  logic [15:0] sign2,
    input  logic [15:0] sign3,
    input  logic [15:0] sign4,
    output logic        step_pulse,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic [1:0]    sync_q;
    logic          stable_q, stable_d, pulse_q, pulse_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   hold_q, hold_d, word;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          diff, deb_done, tc;

    always_comb begin
        diff     = sync_q[1] ^ stable_q;
        deb_done = diff && (cnt_q == DMAX);
        stable_d = deb_done ? sync_q[1] : stable_q;
        cnt_d    = (!diff || deb_done) ? '0 : cnt_q + 1'b1;
        // pulse registered on the edge where stable rises, so only 0->1 counts
        pulse_d  = stable_d & ~stable_q;
        tc       = presc_q == PMAX;
        presc_d  = tc ? '0 : presc_q + 1'b1;
        idx_d    = tc ? idx_q + 2'd1 : idx_q;
        word     = sel == 2'd0 ? sign1 : sel == 2'd1 ? sign2 : sel == 2'd2 ? sign3 : sign4;
        // load only at the end of digit 3 so a scan never mixes two words
        hold_d   = (tc && idx_q == 2'd3) ? word : hold_q;
        an_d     = ~(4'b0001 << idx_q);
        seg_d    = {1'b1, hex7(hold_q[{idx_q, 2'b00} +: 4])};
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            hold_q   <= '0;
            an_q     <= 4'hF;
            seg_q    <= 8'hFF;
        end else begin
            sync_q   <= {sync_q[0], btn_step};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign step_pulse = pulse_q;
    assign an         = an_q;
    assign seg        = seg_q;
endmodule

// File: tb/tb_seg_scan_step.sv
// tb_seg_scan_step: scoreboard bench for seg_scan_step with directed display and button scenarios.
module tb_seg_scan_step;
    logic        CLK = 1'b0, Reset = 1'b0, btn_step = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] sign1 = '0, sign2 = '0, sign3 = '0, sign4 = '0;
    logic        step_pulse;
    logic [3:0]  an;
    logic [7:0]  seg;

    seg_scan_step #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .CLK(CLK), .Reset(Reset), .btn_step(btn_step), .sel(sel),
        .sign1(sign1), .sign2(sign2), .sign3(sign3), .sign4(sign4),
        .step_pulse(step_pulse), .an(an), .seg(seg)
    );

    always #5 CLK = ~CLK;

    typedef struct {int cyc; logic [3:0] an; logic [7:0] seg;} disp_t;
    disp_t      dq[$];
    int         pq[$];
    disp_t      de;
    int         pe;
    int         cyc = 0, base = 0, total = 0, passed = 0, npulse = 0, n0 = 0;
    bit         mon_on = 1'b0;
    logic [3:0] prev_an;
    logic [7:0] prev_seg;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string msg);
        total++;
        if (ok) passed++;
        else $display("FAIL %s", msg);
    endtask

    always @(negedge CLK) begin
        if (step_pulse) begin
            npulse++;
            if (pq.size() == 0) chk(1'b0, $sformatf("pulse: got pulse at cycle %0d, required none", cyc));
            else begin
                pe = pq.pop_front();
                chk(cyc == pe, $sformatf("pulse: got pulse at cycle %0d, required cycle %0d", cyc, pe));
            end
        end
        if (mon_on && (an !== prev_an || seg !== prev_seg)) begin
            if (dq.size() == 0) chk(1'b0, $sformatf("disp: got an=%b seg=%h at cycle %0d, required no change", an, seg, cyc));
            else begin
                de = dq.pop_front();
                chk(cyc == de.cyc && an === de.an && seg === de.seg,
                    $sformatf("disp: got cycle %0d an=%b seg=%h, required cycle %0d an=%b seg=%h",
                              cyc, an, seg, de.cyc, de.an, de.seg));
            end
        end
        prev_an  = an;
        prev_seg = seg;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_to(input int k);
        tick(base + k - cyc);
    endtask

    task automatic push_scan(input int k, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        dq.push_back('{base + k, 4'b1110, s0});
        dq.push_back('{base + k + 4, 4'b1101, s1});
        dq.push_back('{base + k + 8, 4'b1011, s2});
        dq.push_back('{base + k + 12, 4'b0111, s3});
    endtask

    task automatic rst_checks(input string tag);
        chk(an === 4'hF, $sformatf("%s an: got %b, required 1111", tag, an));
        chk(seg === 8'hFF, $sformatf("%s seg: got %h, required ff", tag, seg));
        chk(step_pulse === 1'b0, $sformatf("%s step_pulse: got %b, required 0", tag, step_pulse));
    endtask

    task automatic do_reset(input int n);
        mon_on = 1'b0;
        Reset = 1'b0;
        tick(n);
        rst_checks("reset");
        Reset = 1'b1;
        base = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        // two full scans of sign3 via sel=2
        sel = 2'd2;
        sign3 = 16'h1A2F;
        do_reset(3);
        mon_on = 1'b1;
        push_scan(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        push_scan(17, 8'h8E, 8'hA4, 8'h88, 8'hF9);
        dq.push_back('{base + 33, 4'b1110, 8'h8E});
        wait_to(35);
        mon_on = 1'b0;
        chk(dq.size() == 0, $sformatf("scan1 pending: got %0d left, required 0", dq.size()));

        // mid-scan sel/sign changes take effect only at the digit-3 load point
        sel = 2'd0;
        sign3 = 16'h0000;
        sign4 = 16'hFFFF;
        do_reset(2);
        mon_on = 1'b1;
        push_scan(1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        push_scan(17, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        push_scan(33, 8'h8E, 8'h8E, 8'h8E, 8'h8E);
        push_scan(49, 8'hB0, 8'h99, 8'h92, 8'h82);
        push_scan(65, 8'h80, 8'h90, 8'h83, 8'hC6);
        push_scan(81, 8'hC0, 8'hF8, 8'hA1, 8'h86);
        dq.push_back('{base + 97, 4'b1110, 8'hC0});
        wait_to(22);
        sel = 2'd3;
        wait_to(34);
        sel = 2'd1;
        sign2 = 16'h6543;
        wait_to(50);
        sel = 2'd2;
        sign3 = 16'hCB98;
        wait_to(66);
        sign3 = 16'hED70;
        wait_to(99);
        mon_on = 1'b0;
        chk(dq.size() == 0, $sformatf("scan2 pending: got %0d left, required 0", dq.size()));

        // bouncing button never settles: no pulse
        n0 = npulse;
        for (int i = 0; i < 40; i++) begin
            btn_step = ((i / 3) % 2) == 0;
            tick(1);
        end
        btn_step = 1'b0;
        tick(20);
        chk(npulse == n0, $sformatf("bounce pulses: got %0d, required 0", npulse - n0));

        // clean held press: one pulse 10 cycles after the press, none on release
        n0 = npulse;
        btn_step = 1'b1;
        base = cyc;
        pq.push_back(base + 10);
        tick(30);
        btn_step = 1'b0;
        tick(20);
        chk(npulse - n0 == 1, $sformatf("press pulses: got %0d, required 1", npulse - n0));
        chk(pq.size() == 0, $sformatf("press pending: got %0d left, required 0", pq.size()));

        // reset at counter=5 aborts the debounce, which restarts from zero
        n0 = npulse;
        btn_step = 1'b1;
        base = cyc;
        tick(7);
        Reset = 1'b0;
        tick(1);
        rst_checks("midreset");
        Reset = 1'b1;
        pq.push_back(base + 18);
        tick(30);
        btn_step = 1'b0;
        tick(20);
        chk(npulse - n0 == 1, $sformatf("midreset pulses: got %0d, required 1", npulse - n0));
        chk(pq.size() == 0, $sformatf("midreset pending: got %0d left, required 0", pq.size()));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
